// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_if
// Description : Bundles the signals between the pipeline and the hazard
//               tracker: decode-stage register fields and the execute-stage
//               redirect on one side, and stall/flush/forward controls plus
//               performance counters on the other.
//   master : pipeline side (drives decode fields and PCSrcE)
//   slave  : hazard tracker side (drives stall/flush/forward and counters)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
);
   logic                      ValidD;
   logic [REG_ADDR_WIDTH-1:0] Rs1D;
   logic [REG_ADDR_WIDTH-1:0] Rs2D;
   logic [REG_ADDR_WIDTH-1:0] RdD;
   logic                      RegWriteD;
   logic                      ResultSrcD;
   logic                      PCSrcE;
   logic                      StallF;
   logic                      StallD;
   logic                      FlushD;
   logic                      FlushE;
   logic [1:0]                ForwardAE;
   logic [1:0]                ForwardBE;
   logic [CNT_WIDTH-1:0]      StallCount;
   logic [CNT_WIDTH-1:0]      FlushCount;

   modport master (
      output ValidD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
             StallCount, FlushCount
   );

   modport slave (
      input  ValidD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
             StallCount, FlushCount
   );
endinterface
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tracker
// Description : Hazard control for a 5-stage RISC-V pipeline. Keeps a shadow
//               copy of the E/M/W stage destinations, raises load-use stalls
//               and branch/jump flushes, selects execute-stage forwarding and
//               counts stall and flush cycles.
// Ports       : clk  - pipeline clock
//               rst  - asynchronous active-high reset
//               hz   - hazard_if.slave: decode fields, PCSrcE in;
//                      StallF/StallD/FlushD/FlushE, ForwardAE/BE,
//                      StallCount/FlushCount out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_tracker #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  wire logic clk,
   input  wire logic rst,
   hazard_if.slave   hz
);

   // Shadow pipeline. The load flag only matters in E (load-use detection),
   // so M and W carry just valid, destination and write-enable.
   logic                      r_v_e, r_v_m, r_v_w;
   logic [REG_ADDR_WIDTH-1:0] r_rs1_e, r_rs2_e;
   logic [REG_ADDR_WIDTH-1:0] r_rd_e, r_rd_m, r_rd_w;
   logic                      r_rw_e, r_rw_m, r_rw_w;
   logic                      r_ld_e;

   logic [CNT_WIDTH-1:0]      r_stall_cnt;
   logic [CNT_WIDTH-1:0]      r_flush_cnt;

   logic                      w_wr_m, w_wr_w;
   logic                      w_load_use;
   logic                      w_stall_f, w_stall_d, w_flush_d, w_flush_e;
   logic [1:0]                w_fwd_a, w_fwd_b;

   // x0 is hard-wired zero, so a stage writing it is never a real producer.
   assign w_wr_m = r_v_m & r_rw_m & (r_rd_m != '0);
   assign w_wr_w = r_v_w & r_rw_w & (r_rd_w != '0);

   assign w_load_use = r_v_e & r_ld_e & r_rw_e & (r_rd_e != '0) & hz.ValidD &
                       ((r_rd_e == hz.Rs1D) | (r_rd_e == hz.Rs2D));

   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_fwd_a   = 2'b00;
      w_fwd_b   = 2'b00;
      if (!rst) begin
         // A taken redirect makes the decode instruction wrong-path, so
         // flushing takes precedence over stalling it.
         if (hz.PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
         end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
         end

         // M is checked first: it holds the younger result.
         if (r_v_e) begin
            if (w_wr_m && (r_rd_m == r_rs1_e))
               w_fwd_a = 2'b10;
            else if (w_wr_w && (r_rd_w == r_rs1_e))
               w_fwd_a = 2'b01;

            if (w_wr_m && (r_rd_m == r_rs2_e))
               w_fwd_b = 2'b10;
            else if (w_wr_w && (r_rd_w == r_rs2_e))
               w_fwd_b = 2'b01;
         end
      end
   end

   assign hz.StallF     = w_stall_f;
   assign hz.StallD     = w_stall_d;
   assign hz.FlushD     = w_flush_d;
   assign hz.FlushE     = w_flush_e;
   assign hz.ForwardAE  = w_fwd_a;
   assign hz.ForwardBE  = w_fwd_b;
   assign hz.StallCount = r_stall_cnt;
   assign hz.FlushCount = r_flush_cnt;

   // The shadow never stalls: a stall simply turns E into a bubble while the
   // real decode register holds its instruction for another cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v_e   <= 1'b0;
         r_v_m   <= 1'b0;
         r_v_w   <= 1'b0;
         r_rs1_e <= '0;
         r_rs2_e <= '0;
         r_rd_e  <= '0;
         r_rd_m  <= '0;
         r_rd_w  <= '0;
         r_rw_e  <= 1'b0;
         r_rw_m  <= 1'b0;
         r_rw_w  <= 1'b0;
         r_ld_e  <= 1'b0;
      end else begin
         r_v_w   <= r_v_m;
         r_rd_w  <= r_rd_m;
         r_rw_w  <= r_rw_m;
         r_v_m   <= r_v_e;
         r_rd_m  <= r_rd_e;
         r_rw_m  <= r_rw_e;
         r_v_e   <= hz.ValidD & ~w_flush_e;
         r_rs1_e <= hz.Rs1D;
         r_rs2_e <= hz.Rs2D;
         r_rd_e  <= hz.RdD;
         r_rw_e  <= hz.RegWriteD;
         r_ld_e  <= hz.ResultSrcD;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_d && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (hz.PCSrcE && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_tracker
// Description : Self-checking bench for hazard_tracker. A reference model of
//               the shadow pipeline produces expected outputs into scoreboard
//               queues; the DUT results are popped and compared each cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_tracker;

   localparam int C_CW = 4;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
   } stage_t;

   logic clk;
   logic rst;

   hazard_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(C_CW)) hz ();

   hazard_tracker #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(C_CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   stage_t      m_e, m_m, m_w;
   int unsigned m_scnt, m_fcnt;
   logic [7:0]  q_out[$];
   logic [7:0]  q_cnt[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic is_writer(input stage_t s);
      return s.v & s.rw & (s.rd != 5'd0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (!m_e.v) return 2'b00;
      if (is_writer(m_m) && (m_m.rd == rs)) return 2'b10;
      if (is_writer(m_w) && (m_w.rd == rs)) return 2'b01;
      return 2'b00;
   endfunction

   // One pipeline cycle: drive decode fields, predict, compare combinational
   // outputs, clock, then compare the counters. wfa/wfb/wst >= 0 add directed
   // checks of ForwardAE/ForwardBE/StallD against hand-derived values.
   task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic pc, input int wfa, input int wfb, input int wst);
      logic       lu;
      logic [3:0] ctl;
      logic [7:0] eo;
      logic [7:0] ec;
      hz.ValidD     = v;
      hz.Rs1D       = rs1;
      hz.Rs2D       = rs2;
      hz.RdD        = rd;
      hz.RegWriteD  = rw;
      hz.ResultSrcD = ld;
      hz.PCSrcE     = pc;
      lu = m_e.v & m_e.ld & m_e.rw & (m_e.rd != 5'd0) & v &
           ((m_e.rd == rs1) | (m_e.rd == rs2));
      if (pc)      ctl = 4'b0011;   // {StallF, StallD, FlushD, FlushE}
      else if (lu) ctl = 4'b1101;
      else         ctl = 4'b0000;
      q_out.push_back({ctl, fwd_sel(m_e.rs1), fwd_sel(m_e.rs2)});
      #2;
      eo = q_out.pop_front();
      check("StallF",    hz.StallF,    eo[7]);
      check("StallD",    hz.StallD,    eo[6]);
      check("FlushD",    hz.FlushD,    eo[5]);
      check("FlushE",    hz.FlushE,    eo[4]);
      check("ForwardAE", hz.ForwardAE, eo[3:2]);
      check("ForwardBE", hz.ForwardBE, eo[1:0]);
      if (wfa >= 0) check("dir_ForwardAE", hz.ForwardAE, wfa);
      if (wfb >= 0) check("dir_ForwardBE", hz.ForwardBE, wfb);
      if (wst >= 0) check("dir_StallD",    hz.StallD,    wst);
      @(posedge clk);
      m_w = m_m;
      m_m = m_e;
      m_e = '{v: v & ~ctl[0], rs1: rs1, rs2: rs2, rd: rd, rw: rw, ld: ld};
      if (ctl[2] && m_scnt < 15) m_scnt++;
      if (pc && m_fcnt < 15)     m_fcnt++;
      q_cnt.push_back({m_scnt[3:0], m_fcnt[3:0]});
      #1;
      ec = q_cnt.pop_front();
      check("StallCount", hz.StallCount, ec[7:4]);
      check("FlushCount", hz.FlushCount, ec[3:0]);
   endtask

   task automatic nop(input int wfa, input int wfb, input int wst);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, wfa, wfb, wst);
   endtask

   task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      step(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, -1, -1, -1);
   endtask

   task automatic load(input logic [4:0] rs1, input logic [4:0] rd);
      step(1'b1, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b0, -1, -1, -1);
   endtask

   // Assert reset with a redirect and a load-use pattern on the inputs; every
   // output and counter must read zero while reset is high.
   task automatic apply_reset();
      hz.ValidD     = 1'b1;
      hz.Rs1D       = 5'd7;
      hz.Rs2D       = 5'd7;
      hz.RdD        = 5'd7;
      hz.RegWriteD  = 1'b1;
      hz.ResultSrcD = 1'b1;
      hz.PCSrcE     = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_StallF",     hz.StallF,     1'b0);
         check("rst_StallD",     hz.StallD,     1'b0);
         check("rst_FlushD",     hz.FlushD,     1'b0);
         check("rst_FlushE",     hz.FlushE,     1'b0);
         check("rst_ForwardAE",  hz.ForwardAE,  2'b00);
         check("rst_ForwardBE",  hz.ForwardBE,  2'b00);
         check("rst_StallCount", hz.StallCount, 4'd0);
         check("rst_FlushCount", hz.FlushCount, 4'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      hz.ValidD     = 1'b0;
      hz.PCSrcE     = 1'b0;
      m_e    = '0;
      m_m    = '0;
      m_w    = '0;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      n_vec = 0;
      n_err = 0;
      apply_reset();
      nop(0, 0, 0);
      nop(0, 0, 0);

      // ALU-ALU back to back: producer in M when consumer in E
      alu(5'd1, 5'd2, 5'd5);
      alu(5'd5, 5'd3, 5'd6);
      nop(2, 0, 0);
      // one independent instruction between: producer in W
      alu(5'd1, 5'd2, 5'd8);
      alu(5'd1, 5'd2, 5'd9);
      alu(5'd8, 5'd4, 5'd10);
      nop(1, 0, 0);

      // load-use: one stall, then the consumer forwards from W
      load(5'd1, 5'd7);
      step(1'b1, 5'd3, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, -1, -1, 1);
      step(1'b1, 5'd3, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, -1, -1, 0);
      nop(-1, 1, 0);
      nop(-1, -1, 0);

      // x0 never stalls nor forwards
      load(5'd1, 5'd0);
      step(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, -1, -1, 0);
      alu(5'd1, 5'd2, 5'd0);
      alu(5'd0, 5'd0, 5'd13);
      nop(0, 0, 0);

      // redirect beats load-use
      load(5'd1, 5'd7);
      step(1'b1, 5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, -1, -1, 0);
      nop(-1, -1, 0);

      // M has priority over W for the same destination
      alu(5'd1, 5'd2, 5'd3);
      alu(5'd1, 5'd2, 5'd3);
      alu(5'd3, 5'd3, 5'd15);
      nop(2, 2, 0);

      // reset in the middle of a load-use with counters nonzero
      load(5'd1, 5'd7);
      apply_reset();
      nop(0, 0, 0);
      step(1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 0, 0, 0);

      // dense random traffic on a few registers
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), -1, -1, -1);
      end

      // saturation: 20 load-use stalls on a 4-bit counter
      apply_reset();
      load(5'd1, 5'd7);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, -1, -1, 1);
         step(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, -1, -1, 0);
      end
      check("sat_StallCount", hz.StallCount, 4'd15);
      check("sat_FlushCount", hz.FlushCount, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Hazard control for the 5-stage RISC-V pipeline; drives the stall and flush inputs of the fetch/decode and decode/execute pipeline registers.
- Takes decode-stage register fields each cycle and keeps its own shadow copy of the in-flight E, M and W stage destinations.
- Produces load-use stalls, branch/jump flushes and execute-stage forwarding selects.
- Counts stall and flush cycles for performance measurement.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- ValidD  in  1  decode stage holds a real instruction
- Rs1D  in  REG_ADDR_WIDTH  decode source register 1
- Rs2D  in  REG_ADDR_WIDTH  decode source register 2
- RdD  in  REG_ADDR_WIDTH  decode destination register
- RegWriteD  in  1  decode instruction writes the register file
- ResultSrcD  in  1  decode instruction is a load (result taken from memory)
- PCSrcE  in  1  taken branch or jump resolved in execute
- StallF  out  1  hold PC
- StallD  out  1  hold fetch/decode register
- FlushD  out  1  clear fetch/decode register
- FlushE  out  1  clear decode/execute register
- ForwardAE  out  2  ALU operand A select: 00 register file, 01 writeback, 10 memory stage
- ForwardBE  out  2  ALU operand B select, same encoding
- StallCount  out  CNT_WIDTH  saturating count of load-use stall cycles
- FlushCount  out  CNT_WIDTH  saturating count of PCSrcE flush cycles

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Shadow state per stage S in {E, M, W}: vS, rdS, rwS, ldS. E additionally holds rs1E and rs2E.
- Reset:
  - All vS, StallCount and FlushCount clear immediately.
  - While rst is high, all outputs are forced to 0 regardless of PCSrcE.
- Effective writer: a stage counts as a writer only when vS & rwS & (rdS != 0). Register x0 never creates a hazard or a forward.
- Load-use condition: vE & ldE & rwE & (rdE != 0) & ValidD & ((rdE == Rs1D) | (rdE == Rs2D)).
- Outputs are combinational from the inputs and the shadow state:
  - PCSrcE = 1: FlushD = 1, FlushE = 1, StallF = 0, StallD = 0. Flush wins over load-use, because the decode instruction is on the wrong path.
  - Otherwise, load-use condition true: StallF = 1, StallD = 1, FlushE = 1, FlushD = 0.
  - Otherwise: all four are 0.
- Forwarding for operand A (operand B identical, using rs2E):
  - If the M stage is an effective writer and rdM == rs1E, ForwardAE = 10.
  - Else if the W stage is an effective writer and rdW == rs1E, ForwardAE = 01.
  - Else ForwardAE = 00.
  - The M stage has priority because it holds the newer value.
  - If vE = 0, the select is 00.
- Shadow update on each rising clk edge:
  - W <= M, and M <= E.
  - If FlushE, then vE <= 0 and the other E fields are don't-care. This is the bubble.
  - Otherwise E <= {ValidD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD}.
  - The shadow pipeline never stalls; a stall only inserts a bubble into E.
- Result: a load-use hazard costs exactly one stall cycle. On the following cycle the load is in M. A dependent instruction then in E still sees ForwardAE/BE = 10, but the datapath must not forward a load from M. The load-use stall guarantees the load reaches W before the consumer executes, so the consumer sees ForwardAE/BE = 01.
- Counters:
  - StallCount increments on every clock where StallD = 1.
  - FlushCount increments on every clock where PCSrcE = 1.
  - Both saturate at all-ones and do not wrap.
  - Counter outputs are registered, so a count is visible one cycle after the event.
- Reset asserted mid-operation: shadow state is lost and outputs drop to 0 asynchronously. The first instruction after release sees no hazards.

Test Plan:
- Reset: assert rst with PCSrcE = 1 and a load in the shadow -> all outputs 0 and counters 0 while rst is high. Release -> outputs still 0 until instructions are presented.
- ALU-ALU forwarding: cycle 0 D = add x5 (RdD 5, RegWriteD 1), cycle 1 D = sub with Rs1D 5, cycle 2 -> ForwardAE = 10. Insert one independent instruction between them instead -> ForwardAE = 01 when the consumer reaches E.
- Load-use: D = lw x7, next D = add with Rs2D 7 -> in that cycle StallF = StallD = FlushE = 1. The next cycle has no stall, and when the add is in E, ForwardBE = 01. StallCount reads 1 one cycle later.
- x0: lw x0 followed by a use of x0 -> no stall. add x0 followed by a use of x0 -> ForwardAE = ForwardBE = 00.
- Branch over load-use: load-use condition true and PCSrcE = 1 in the same cycle -> FlushD = FlushE = 1, StallF = StallD = 0. FlushCount increments and StallCount does not.
- Priority and saturation: rdM = rdW = 3 (both effective writers) and rs1E = 3 -> ForwardAE = 10. With CNT_WIDTH = 4, hold the stall for 20 cycles -> StallCount stays at 15.
